irq_trap_ctrl: RTL and testbench

- Machine-mode interrupt/trap sequencer for the RV32 core.
- Samples the external (DMA) and timer (WDT) interrupt lines and decides when a trap is taken, using the mstatus/mie state from the CSR register file.
- Sequences the CSR writes for trap entry, MRET and WFI through a single CSR write port into the register file, flushes the pipeline and redirects fetch.
- Sits between the pipeline control logic and the CSR portion of the register file.

---
 rtl/csr_pkg.sv | 34 +++
 rtl/irq_trap_ctrl_if.sv | 23 ++
 rtl/irq_trap_ctrl_sync.sv | 18 +
 rtl/irq_trap_ctrl.sv | 139 +++++++++++++
 tb/tb_irq_trap_ctrl.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/csr_pkg.sv
// Shared CSR encodings, mstatus/mie bit positions, trap causes and the
// trap sequencer state type.
package csr_pkg;

  localparam logic [3:0] MSTATUS  = 4'd0;
  localparam logic [3:0] MTVEC    = 4'd1;
  localparam logic [3:0] MIE      = 4'd2;
  localparam logic [3:0] MIP      = 4'd3;
  localparam logic [3:0] MEPC     = 4'd4;
  localparam logic [3:0] INSTRETH = 4'd5;
  localparam logic [3:0] INSTRET  = 4'd6;
  localparam logic [3:0] CYCLEH   = 4'd7;
  localparam logic [3:0] CYCLE    = 4'd8;

  localparam int MIE_BIT  = 3;
  localparam int MPIE_BIT = 7;
  localparam int MPP_LSB  = 11;
  localparam int MEIE_BIT = 11;
  localparam int MTIE_BIT = 7;

  localparam logic [31:0] CAUSE_MEI = 32'h8000_000B;
  localparam logic [31:0] CAUSE_MTI = 32'h8000_0007;

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    SAVE_EPC,
    SAVE_STAT,
    REDIRECT,
    WFI,
    MRET_WR
  } trap_state_t;

endpackage

// File: rtl/irq_trap_ctrl_if.sv
// CSR-side bus of the trap sequencer: CSR state in, single write port and
// synchronized mip bits out.
interface irq_trap_ctrl_if #(parameter int XLEN = 32);
  logic [XLEN-1:0] mstatus_q;
  logic [XLEN-1:0] mie_q;
  logic [XLEN-1:0] mtvec_q;
  logic [XLEN-1:0] mepc_q;
  logic            csr_wr_en;
  logic [3:0]      csr_wr_addr;
  logic [XLEN-1:0] csr_wr_data;
  logic            mip_meip;
  logic            mip_mtip;

  modport master (
    input  mstatus_q, mie_q, mtvec_q, mepc_q,
    output csr_wr_en, csr_wr_addr, csr_wr_data, mip_meip, mip_mtip
  );

  modport slave (
    output mstatus_q, mie_q, mtvec_q, mepc_q,
    input  csr_wr_en, csr_wr_addr, csr_wr_data, mip_meip, mip_mtip
  );
endinterface

// File: rtl/irq_trap_ctrl_sync.sv
// Multi-flop synchronizer for an asynchronous level input.
module irq_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sr <= '0;
    else     sr <= (sr << 1) | STAGES'(d);
  end

  assign q = sr[STAGES-1];
endmodule

// File: rtl/irq_trap_ctrl.sv
// Machine-mode interrupt/trap sequencer: decides trap entry, sequences the
// CSR writes for trap entry / MRET / WFI and redirects fetch.
//
// state     | meaning
// IDLE      | normal execution, watching for trap, MRET or WFI
// DRAIN     | trap pending, waiting for the pipeline to become flushable
// SAVE_EPC  | write mepc, flush, pulse trap_taken
// SAVE_STAT | write trap-entry mstatus, flush
// REDIRECT  | fetch from mtvec, flush
// WFI       | pipeline frozen until an enabled interrupt is pending
// MRET_WR   | write return mstatus, fetch from mepc, flush
module irq_trap_ctrl
  import csr_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int XLEN        = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ext_irq,
  input  logic            tmr_irq,
  irq_trap_ctrl_if.master csr,
  input  logic [XLEN-1:0] commit_pc,
  input  logic            is_mret,
  input  logic            is_wfi,
  input  logic            pipe_stall,
  output logic            irq_flush,
  output logic            pc_sel,
  output logic [XLEN-1:0] pc_target,
  output logic            wfi_stall,
  output logic            trap_taken,
  output logic [XLEN-1:0] trap_cause
);
  localparam logic [XLEN-1:0] C_MEI = XLEN'(CAUSE_MEI);
  localparam logic [XLEN-1:0] C_MTI = XLEN'(CAUSE_MTI);

  trap_state_t     state, next;
  logic            meip, mtip, pend_e, pend_t, pend_any, take;
  logic [XLEN-1:0] epc_q;
  logic [XLEN-1:0] stat_trap, stat_mret;
  logic            unused_ok;

  irq_sync #(.STAGES(SYNC_STAGES)) u_sync_ext (.clk(clk), .rst(rst), .d(ext_irq), .q(meip));
  irq_sync #(.STAGES(SYNC_STAGES)) u_sync_tmr (.clk(clk), .rst(rst), .d(tmr_irq), .q(mtip));

  assign csr.mip_meip = meip;
  assign csr.mip_mtip = mtip;
  assign pend_e   = meip & csr.mie_q[MEIE_BIT];
  assign pend_t   = mtip & csr.mie_q[MTIE_BIT];
  assign pend_any = pend_e | pend_t;
  assign take     = csr.mstatus_q[MIE_BIT] & pend_any;
  assign unused_ok = ^{csr.mie_q, csr.mtvec_q[1:0]};

  always_comb begin
    stat_trap = csr.mstatus_q;
    stat_trap[MPIE_BIT]        = csr.mstatus_q[MIE_BIT];
    stat_trap[MIE_BIT]         = 1'b0;
    stat_trap[MPP_LSB +: 2]    = 2'b11;
    stat_mret = csr.mstatus_q;
    stat_mret[MIE_BIT]         = csr.mstatus_q[MPIE_BIT];
    stat_mret[MPIE_BIT]        = 1'b1;
    stat_mret[MPP_LSB +: 2]    = 2'b11;
  end

  always_comb begin
    next            = state;
    csr.csr_wr_en   = 1'b0;
    csr.csr_wr_addr = MSTATUS;
    csr.csr_wr_data = '0;
    irq_flush       = 1'b0;
    pc_sel          = 1'b0;
    pc_target       = '0;
    wfi_stall       = 1'b0;
    case (state)
      IDLE: begin
        if (is_mret)                 next = MRET_WR;
        else if (take && pipe_stall) next = DRAIN;
        else if (take)               next = SAVE_EPC;
        else if (is_wfi && !pend_any) next = WFI;
      end
      DRAIN: begin
        if (!pipe_stall) next = take ? SAVE_EPC : IDLE;
      end
      SAVE_EPC: begin
        csr.csr_wr_en   = 1'b1;
        csr.csr_wr_addr = MEPC;
        csr.csr_wr_data = epc_q;
        irq_flush       = 1'b1;
        next            = SAVE_STAT;
      end
      SAVE_STAT: begin
        csr.csr_wr_en   = 1'b1;
        csr.csr_wr_addr = MSTATUS;
        csr.csr_wr_data = stat_trap;
        irq_flush       = 1'b1;
        next            = REDIRECT;
      end
      REDIRECT: begin
        pc_sel    = 1'b1;
        pc_target = {csr.mtvec_q[XLEN-1:2], 2'b00};
        irq_flush = 1'b1;
        next      = IDLE;
      end
      WFI: begin
        wfi_stall = 1'b1;
        if (pend_any) next = csr.mstatus_q[MIE_BIT] ? SAVE_EPC : IDLE;
      end
      MRET_WR: begin
        csr.csr_wr_en   = 1'b1;
        csr.csr_wr_addr = MSTATUS;
        csr.csr_wr_data = stat_mret;
        pc_sel          = 1'b1;
        pc_target       = csr.mepc_q;
        irq_flush       = 1'b1;
        next            = IDLE;
      end
      default: next = IDLE;
    endcase
  end

  // epc holds commit_pc for a direct trap, or the PC after the WFI for a wake-up trap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      epc_q      <= '0;
      trap_cause <= '0;
      trap_taken <= 1'b0;
    end else begin
      state      <= next;
      trap_taken <= (next == SAVE_EPC);
      if (state == IDLE && next == WFI)
        epc_q <= commit_pc + XLEN'(4);
      else if (state != WFI && next == SAVE_EPC)
        epc_q <= commit_pc;
      if (next == SAVE_EPC)
        trap_cause <= pend_e ? C_MEI : C_MTI;
    end
  end
endmodule

// File: tb/tb_irq_trap_ctrl.sv
// Directed self-checking bench for irq_trap_ctrl with a minimal mstatus model.
module tb_irq_trap_ctrl;
  import csr_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ext_irq, tmr_irq, is_mret, is_wfi, pipe_stall;
  logic [31:0] commit_pc;
  logic        irq_flush, pc_sel, wfi_stall, trap_taken;
  logic [31:0] pc_target, trap_cause;
  logic        ld;
  logic [31:0] ld_val;
  int          checks = 0;
  int          failures = 0;

  irq_trap_ctrl_if #(.XLEN(32)) csr_bus ();

  irq_trap_ctrl #(.SYNC_STAGES(2), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .ext_irq(ext_irq), .tmr_irq(tmr_irq), .csr(csr_bus),
    .commit_pc(commit_pc), .is_mret(is_mret), .is_wfi(is_wfi), .pipe_stall(pipe_stall),
    .irq_flush(irq_flush), .pc_sel(pc_sel), .pc_target(pc_target), .wfi_stall(wfi_stall),
    .trap_taken(trap_taken), .trap_cause(trap_cause)
  );

  always #5 clk = ~clk;

  // CSR file stand-in: applies the DUT's mstatus writes at the next edge
  always @(posedge clk) begin
    if (ld) csr_bus.mstatus_q <= ld_val;
    else if (csr_bus.csr_wr_en && csr_bus.csr_wr_addr == MSTATUS)
      csr_bus.mstatus_q <= csr_bus.csr_wr_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check(tag, {27'd0, csr_bus.csr_wr_en, irq_flush, pc_sel, wfi_stall, trap_taken}, 32'd0);
  endtask

  task automatic load_mstatus(input logic [31:0] v);
    ld = 1'b1;
    ld_val = v;
    tick();
    ld = 1'b0;
  endtask

  task automatic check_save_epc(input string tag, input logic [31:0] exp_epc);
    check({tag, "_epc_we"}, {31'd0, csr_bus.csr_wr_en}, 32'd1);
    check({tag, "_epc_addr"}, {28'd0, csr_bus.csr_wr_addr}, {28'd0, MEPC});
    check({tag, "_epc_data"}, csr_bus.csr_wr_data, exp_epc);
    check({tag, "_epc_taken"}, {30'd0, trap_taken, irq_flush}, 32'd3);
  endtask

  initial begin
    rst = 1'b1; ext_irq = 0; tmr_irq = 0; is_mret = 0; is_wfi = 0; pipe_stall = 0;
    commit_pc = 0; ld = 1'b1; ld_val = 0;
    csr_bus.mie_q = 32'h0000_0880; csr_bus.mtvec_q = 32'h0001_0000; csr_bus.mepc_q = 0;
    #3;
    check_quiet("reset_strobes");
    check("reset_cause", trap_cause, 0);
    check("reset_mip", {30'd0, csr_bus.mip_meip, csr_bus.mip_mtip}, 0);
    tick();
    rst = 1'b0;
    ld = 1'b0;
    load_mstatus(32'h8);

    // external interrupt trap entry
    commit_pc = 32'h124; ext_irq = 1;
    tick(); check("sync_lat1", {31'd0, csr_bus.mip_meip}, 0);
    tick(); check("sync_lat2", {31'd0, csr_bus.mip_meip}, 1); check_quiet("t1_idle");
    tick(); check_save_epc("t1", 32'h124); check("t1_epc_pcsel", {31'd0, pc_sel}, 0);
    tick();
    check("t1_stat_addr", {28'd0, csr_bus.csr_wr_addr}, {28'd0, MSTATUS});
    check("t1_stat_data", csr_bus.csr_wr_data, 32'h1880);
    check("t1_stat_taken", {31'd0, trap_taken}, 0);
    tick();
    check("t1_redir", {30'd0, pc_sel, csr_bus.csr_wr_en}, 32'd2);
    check("t1_target", pc_target, 32'h0001_0000);
    tick(); check_quiet("t1_done"); check("t1_cause", trap_cause, 32'h8000_000B);
    ext_irq = 0; tick(); tick();

    // simultaneous external and timer
    load_mstatus(32'h8);
    ext_irq = 1; tmr_irq = 1;
    tick(); tick();
    tick(); check_save_epc("t2", 32'h124);
    tick(); tick();
    tick(); check("t2_cause", trap_cause, 32'h8000_000B); check_quiet("t2_done");
    tick(); check_quiet("t2_single_a");
    tick(); check_quiet("t2_single_b");
    ext_irq = 0; tmr_irq = 0; tick(); tick();

    // drain while pipeline busy
    load_mstatus(32'h8);
    pipe_stall = 1; commit_pc = 32'h140; ext_irq = 1;
    tick(); tick(); tick();
    for (int i = 0; i < 4; i++) begin
      check_quiet("t3_drain");
      tick();
    end
    check_quiet("t3_drain_last");
    pipe_stall = 0;
    tick(); check_save_epc("t3", 32'h140);
    tick(); tick(); tick();
    ext_irq = 0; tick(); tick();

    // drain abandoned when the interrupt drops
    load_mstatus(32'h8);
    pipe_stall = 1; ext_irq = 1;
    tick(); tick(); tick();
    ext_irq = 0;
    tick(); tick(); check_quiet("t3b_drain");
    pipe_stall = 0;
    tick(); check_quiet("t3b_idle_a");
    tick(); check_quiet("t3b_idle_b");
    check("t3b_no_write", csr_bus.mstatus_q, 32'h8);

    // MRET with timer pending behind it
    load_mstatus(32'h1880);
    csr_bus.mepc_q = 32'h200; tmr_irq = 1;
    tick(); tick(); check_quiet("t4_masked");
    is_mret = 1;
    tick(); is_mret = 0; commit_pc = 32'h208;
    check("t4_mret_addr", {28'd0, csr_bus.csr_wr_addr, 3'd0, csr_bus.csr_wr_en}, {28'd0, MSTATUS, 4'd1});
    check("t4_mret_data", csr_bus.csr_wr_data, 32'h1888);
    check("t4_mret_pc", pc_target, 32'h200);
    check("t4_mret_flush", {30'd0, pc_sel, irq_flush}, 32'd3);
    tick(); check_quiet("t4_idle");
    tick(); check_save_epc("t4", 32'h208);
    tick(); check("t4_stat_data", csr_bus.csr_wr_data, 32'h1880);
    tick(); tick(); check("t4_cause", trap_cause, 32'h8000_0007);
    tmr_irq = 0; tick(); tick();

    // WFI with MIE=0: wake without trap
    commit_pc = 32'h300; is_wfi = 1;
    tick(); is_wfi = 0; commit_pc = 32'h500;
    check("t5_stall", {31'd0, wfi_stall}, 1);
    tick(); check("t5_stall_hold", {30'd0, wfi_stall, csr_bus.csr_wr_en}, 32'd2);
    tmr_irq = 1;
    tick(); tick(); check("t5_stall_sync", {31'd0, wfi_stall}, 1);
    tick(); check_quiet("t5_wake"); check("t5_cause_keep", trap_cause, 32'h8000_0007);
    is_wfi = 1;
    tick(); is_wfi = 0; check_quiet("t5_wfi_nop");
    tmr_irq = 0; tick(); tick();

    // WFI with MIE=1: wake into trap, epc = wfi_pc + 4
    load_mstatus(32'h8);
    commit_pc = 32'h300; is_wfi = 1;
    tick(); is_wfi = 0; commit_pc = 32'h500;
    ext_irq = 1;
    tick(); tick(); check("t6_stall", {31'd0, wfi_stall}, 1);
    tick(); check_save_epc("t6", 32'h304); check("t6_unstall", {31'd0, wfi_stall}, 0);
    tick(); tick(); tick(); check("t6_cause", trap_cause, 32'h8000_000B);
    ext_irq = 0; tick(); tick();

    // wfi_pc + 4 wraps; mtvec low bits masked
    csr_bus.mtvec_q = 32'h0002_0003;
    load_mstatus(32'h8);
    commit_pc = 32'hFFFF_FFFC; is_wfi = 1;
    tick(); is_wfi = 0; tmr_irq = 1;
    tick(); tick();
    tick(); check_save_epc("t7", 32'h0);
    tick();
    tick(); check("t7_target", pc_target, 32'h0002_0000);
    tick(); check("t7_cause", trap_cause, 32'h8000_0007);
    tmr_irq = 0; tick(); tick();

    // reset during SAVE_STAT
    load_mstatus(32'h8);
    ext_irq = 1;
    tick(); tick(); tick(); tick();
    check("t8_in_stat", {28'd0, csr_bus.csr_wr_addr, 3'd0, csr_bus.csr_wr_en}, {28'd0, MSTATUS, 4'd1});
    rst = 1; #1;
    check_quiet("t8_rst_strobes");
    check("t8_rst_cause", trap_cause, 0);
    check("t8_rst_mip", {31'd0, csr_bus.mip_meip}, 0);
    tick(); rst = 0; ext_irq = 0;
    tick(); check_quiet("t8_after_a");
    tick(); check_quiet("t8_after_b");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
